pmod_dac_rx: RTL

//  Receive side of the PMOD DAC serial link (cs_n/sclk/din/ldac_n) driven by pmod_dac_block.
//  - Oversamples the four pins in the clk domain, deserializes MSB-first 16-bit frames into
//    an input register, and transfers that register to the DAC output register on LDAC.
//  - Serves as the fabric-side DAC model for loopback checks of asic_function_interface
//    and as the front end of emulated ASIC function blocks.

---
 rtl/pmod_dac_rx.sv | 106 ++++++++++
 1 files changed

// File: rtl/pmod_dac_rx.sv
// pmod_dac_rx: PMOD DAC serial receiver (ports: clk, rst async high, dac_cs_n/sclk/din/ldac_n pins; input_reg, dac_value, pending, frame_valid, update_valid, frame_err, busy, frame_cnt/err_cnt counters enabled by PMOD_DAC_RX_STATS_EN)
module pmod_dac_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dac_cs_n,
  input  logic                  dac_sclk,
  input  logic                  dac_din,
  input  logic                  dac_ldac_n,
  output logic [DATA_WIDTH-1:0] input_reg,
  output logic [DATA_WIDTH-1:0] dac_value,
  output logic                  pending,
  output logic                  frame_valid,
  output logic                  update_valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
);
  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_OK  = CW'(DATA_WIDTH);
  localparam logic [3:0] PIN_IDLE = 4'b1001;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  logic [3:0] sync [SYNC_STAGES];
  logic [2:0] hist;
  logic [SYNC_STAGES:0] rdy;
  logic [3:0] s;
  logic cs_fall, cs_rise, sclk_rise, ldac_fall, en;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0] bit_cnt;
  logic good;
  assign s  = sync[SYNC_STAGES-1];
  // events stay masked until the chain has flushed its reset levels, so a pin
  // already low at reset release never looks like a fresh edge
  assign en        = rdy[SYNC_STAGES];
  assign cs_fall   = en & ~s[0] &  hist[0];
  assign cs_rise   = en &  s[0] & ~hist[0];
  assign sclk_rise = en &  s[1] & ~hist[1];
  assign ldac_fall = en & ~s[3] &  hist[2];
  assign good      = (state == CHECK) && (bit_cnt == CNT_OK);
  assign busy      = (state == SHIFT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= PIN_IDLE;
      hist <= {PIN_IDLE[3], PIN_IDLE[1], PIN_IDLE[0]};
      rdy  <= '0;
    end else begin
      sync[0] <= {dac_ldac_n, dac_din, dac_sclk, dac_cs_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hist <= {s[3], s[1], s[0]};
      rdy  <= {rdy[SYNC_STAGES-1:0], 1'b1};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      input_reg    <= '0;
      dac_value    <= '0;
      pending      <= 1'b0;
      frame_valid  <= 1'b0;
      update_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_valid  <= good;
      frame_err    <= (state == CHECK) && !good;
      update_valid <= ldac_fall && pending;
      if (ldac_fall && pending) dac_value <= input_reg;
      if (good) input_reg <= shift_reg;
      pending <= good ? 1'b1 : (ldac_fall ? 1'b0 : pending);
      case (state)
        IDLE:
          if (cs_fall) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        SHIFT:
          if (cs_rise) state <= CHECK;
          else if (sclk_rise) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], s[2]};
            bit_cnt   <= (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef PMOD_DAC_RX_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_valid && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
      if (frame_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif
endmodule
